// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream and RAM control signals of the RAM-backed FIFO controller.
// The bidirectional RAM data bus stays a plain inout port on the controller.
interface ram_fifo_ctrl_if #(
   parameter int WIDTH    = 16,
   parameter int ADDR_BUS = 3
);
   logic                push;
   logic [WIDTH-1:0]    din;
   logic                push_rdy;
   logic                pop;
   logic                pop_rdy;
   logic [WIDTH-1:0]    dout;
   logic                dout_valid;
   logic                empty;
   logic                full;
   logic [ADDR_BUS:0]   count;
   logic                ram_we;
   logic                ram_re;
   logic [ADDR_BUS-1:0] ram_addr;

   modport slave (
      input  push, din, pop,
      output push_rdy, pop_rdy, dout, dout_valid, empty, full, count,
             ram_we, ram_re, ram_addr
   );

   modport master (
      output push, din, pop,
      input  push_rdy, pop_rdy, dout, dout_valid, empty, full, count,
             ram_we, ram_re, ram_addr
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller using a single-port RAM as storage: serialises pushes and pops
// onto one address port and a shared bidirectional data bus.
module ram_fifo_ctrl #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int ADDR_BUS = 3
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   ram_fifo_ctrl_if.slave bus,
   inout  wire [WIDTH-1:0] ram_data_io
);
   localparam logic [ADDR_BUS:0]   FULL_CNT = DEPTH[ADDR_BUS:0];
   localparam logic [ADDR_BUS:0]   CNT_ONE  = (ADDR_BUS + 1)'(1'b1);
   localparam logic [ADDR_BUS-1:0] PTR_ONE  = ADDR_BUS'(1'b1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_READ    = 2'd2,
      S_CAPTURE = 2'd3
   } state_e;

   state_e              state_q,    state_d;
   logic [ADDR_BUS-1:0] wr_ptr_q,   wr_ptr_d;
   logic [ADDR_BUS-1:0] rd_ptr_q,   rd_ptr_d;
   logic [ADDR_BUS:0]   count_q,    count_d;
   logic [WIDTH-1:0]    wdata_q,    wdata_d;
   logic [WIDTH-1:0]    dout_q,     dout_d;
   logic                dout_vld_q, dout_vld_d;
   logic                ram_we_q,   ram_we_d;
   logic                ram_re_q,   ram_re_d;
   logic [ADDR_BUS-1:0] ram_addr_q, ram_addr_d;

   logic empty, full, in_idle, pop_rdy, push_rdy, pop_acc, push_acc;

   // Pop wins over a simultaneous push, so push_rdy drops whenever a pop can be taken.
   assign in_idle  = (state_q == S_IDLE);
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign pop_rdy  = in_idle && !empty;
   assign push_rdy = in_idle && !full && !(bus.pop && !empty);
   assign pop_acc  = bus.pop && pop_rdy;
   assign push_acc = bus.push && push_rdy;

   // Next-state and registered-output logic of the access sequencer.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wdata_d    = wdata_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      ram_we_d   = ram_we_q;
      ram_re_d   = ram_re_q;
      ram_addr_d = ram_addr_q;
      case (state_q)
         S_IDLE: begin
            if (pop_acc) begin
               state_d    = S_READ;
               ram_re_d   = 1'b1;
               ram_addr_d = rd_ptr_q;
            end else if (push_acc) begin
               state_d    = S_WRITE;
               ram_we_d   = 1'b1;
               wdata_d    = bus.din;
               ram_addr_d = wr_ptr_q;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_WRITE: begin
            state_d  = S_IDLE;
            ram_we_d = 1'b0;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
         end
         // Address and read enable stay up through CAPTURE so registered-read RAMs also work.
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_d    = S_IDLE;
            ram_re_d   = 1'b0;
            dout_d     = ram_data_io;
            dout_vld_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            count_d    = count_q - CNT_ONE;
         end
         default: begin
            state_d  = S_IDLE;
            ram_we_d = 1'b0;
            ram_re_d = 1'b0;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset abandons any access in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wdata_q    <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wdata_q    <= wdata_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         ram_we_q   <= ram_we_d;
         ram_re_q   <= ram_re_d;
         ram_addr_q <= ram_addr_d;
      end
   end

   assign ram_data_io    = (ram_we_q && !ram_re_q) ? wdata_q : {WIDTH{1'bz}};
   assign bus.push_rdy   = push_rdy;
   assign bus.pop_rdy    = pop_rdy;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_vld_q;
   assign bus.empty      = empty;
   assign bus.full       = full;
   assign bus.count      = count_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_re     = ram_re_q;
   assign bus.ram_addr   = ram_addr_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: vector table of push/pop operations,
// hand-written corner sequences, and a scoreboard queue for popped data.
module tb_ram_fifo_ctrl;
   localparam logic [15:0] IDLE_BUS = 16'hBEEF;

   typedef struct {
      bit          is_pop;
      logic [15:0] din;
      logic        exp_rdy;
      logic [3:0]  exp_count;
   } vec_t;

   logic        clk;
   logic        rst_n;
   wire  [15:0] ram_data;
   logic [15:0] mem [8];
   logic [15:0] exp_q [$];
   logic [2:0]  exp_wptr;
   logic [2:0]  exp_rptr;
   logic        mon_en;
   int          checks;
   int          failures;
   vec_t        vecs [$];

   ram_fifo_ctrl_if #(.WIDTH(16), .ADDR_BUS(3)) bus ();

   ram_fifo_ctrl #(.WIDTH(16), .DEPTH(8), .ADDR_BUS(3)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .ram_data_io (ram_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational-read RAM model; parks a known pattern on the bus when nobody else drives it.
   assign ram_data = bus.ram_we ? {16{1'bz}} : (bus.ram_re ? mem[bus.ram_addr] : IDLE_BUS);

   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= ram_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("no_contention", 32'(bus.ram_we && bus.ram_re), 32'd0);
         if (!bus.ram_we && !bus.ram_re) chk("bus_released", 32'(ram_data), 32'(IDLE_BUS));
         if (bus.dout_valid) begin
            if (exp_q.size() == 0) chk("dout_unexpected", 32'(bus.dout_valid), 32'd0);
            else chk("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_wptr = 3'd0;
      exp_rptr = 3'd0;
   endtask

   // Tasks start and end just after a falling edge.
   task automatic do_push(input logic [15:0] d, input logic exp_ok);
      bus.push = 1'b1;
      bus.din  = d;
      bus.pop  = 1'b0;
      #1;
      chk("push_rdy", 32'(bus.push_rdy), 32'(exp_ok));
      @(negedge clk);
      bus.push = 1'b0;
      if (exp_ok) begin
         exp_q.push_back(d);
         chk("wr_we", 32'(bus.ram_we), 32'd1);
         chk("wr_re", 32'(bus.ram_re), 32'd0);
         chk("wr_addr", 32'(bus.ram_addr), 32'(exp_wptr));
         chk("wr_data", 32'(ram_data), 32'(d));
         exp_wptr++;
         @(negedge clk);
      end else begin
         chk("rej_we", 32'(bus.ram_we), 32'd0);
      end
   endtask

   task automatic do_pop(input logic exp_ok);
      bus.pop  = 1'b1;
      bus.push = 1'b0;
      #1;
      chk("pop_rdy", 32'(bus.pop_rdy), 32'(exp_ok));
      @(negedge clk);
      bus.pop = 1'b0;
      if (exp_ok) begin
         chk("rd_re", 32'(bus.ram_re), 32'd1);
         chk("rd_we", 32'(bus.ram_we), 32'd0);
         chk("rd_addr", 32'(bus.ram_addr), 32'(exp_rptr));
         @(negedge clk);
         chk("cap_re", 32'(bus.ram_re), 32'd1);
         chk("cap_addr", 32'(bus.ram_addr), 32'(exp_rptr));
         chk("cap_valid", 32'(bus.dout_valid), 32'd0);
         @(negedge clk);
         chk("dout_valid", 32'(bus.dout_valid), 32'd1);
         exp_rptr++;
      end else begin
         chk("rej_re", 32'(bus.ram_re), 32'd0);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] c);
      chk({tag, "_count"}, 32'(bus.count), 32'(c));
      chk({tag, "_empty"}, 32'(bus.empty), 32'(c == 4'd0));
      chk({tag, "_full"}, 32'(bus.full), 32'(c == 4'd8));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mon_en   = 1'b0;
      exp_wptr = 3'd0;
      exp_rptr = 3'd0;

      // Fill/overflow, drain with pointer wrap, refill, empty and underflow.
      for (int i = 1; i <= 8; i++) vecs.push_back('{1'b0, 16'(i), 1'b1, 4'(i)});
      vecs.push_back('{1'b0, 16'hFFFF, 1'b0, 4'd8});
      for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 16'h0000, 1'b1, 4'(7 - i)});
      for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 16'(9 + i), 1'b1, 4'(6 + i)});
      for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 16'h0000, 1'b1, 4'(7 - i)});
      vecs.push_back('{1'b1, 16'h0000, 1'b0, 4'd0});

      rst_n    = 1'b0;
      bus.push = 1'b1;
      bus.pop  = 1'b1;
      bus.din  = 16'hFFFF;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      chk_flags("rst", 4'd0);
      chk("rst_we", 32'(bus.ram_we), 32'd0);
      chk("rst_re", 32'(bus.ram_re), 32'd0);
      chk("rst_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_push_rdy", 32'(bus.push_rdy), 32'd1);
      chk("rst_pop_rdy", 32'(bus.pop_rdy), 32'd0);
      rst_n    = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;

      do_push(16'hA465, 1'b1);
      chk_flags("single_push", 4'd1);
      do_pop(1'b1);
      chk_flags("single_pop", 4'd0);

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_pop) do_pop(vecs[i].exp_rdy);
         else do_push(vecs[i].din, vecs[i].exp_rdy);
         chk_flags($sformatf("vec%0d", i), vecs[i].exp_count);
      end

      // Simultaneous push and pop with two words stored: pop first, push held and taken later.
      do_push(16'h1111, 1'b1);
      do_push(16'h2222, 1'b1);
      bus.push = 1'b1;
      bus.din  = 16'h3333;
      bus.pop  = 1'b1;
      #1;
      chk("sim_pop_rdy", 32'(bus.pop_rdy), 32'd1);
      chk("sim_push_rdy", 32'(bus.push_rdy), 32'd0);
      @(negedge clk);
      bus.pop = 1'b0;
      chk("sim_read_re", 32'(bus.ram_re), 32'd1);
      chk("sim_read_push_rdy", 32'(bus.push_rdy), 32'd0);
      @(negedge clk);
      chk("sim_cap_push_rdy", 32'(bus.push_rdy), 32'd0);
      @(negedge clk);
      exp_rptr++;
      chk("sim_valid", 32'(bus.dout_valid), 32'd1);
      chk("sim_push_rdy_back", 32'(bus.push_rdy), 32'd1);
      exp_q.push_back(16'h3333);
      @(negedge clk);
      bus.push = 1'b0;
      chk("sim_wr_we", 32'(bus.ram_we), 32'd1);
      chk("sim_wr_addr", 32'(bus.ram_addr), 32'(exp_wptr));
      exp_wptr++;
      @(negedge clk);
      chk_flags("sim_end", 4'd2);

      // Reset while a write is in flight.
      do_reset();
      bus.push = 1'b1;
      bus.din  = 16'h5555;
      @(negedge clk);
      bus.push = 1'b0;
      chk("mw_we", 32'(bus.ram_we), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_flags("mw", 4'd0);
      chk("mw_we_after", 32'(bus.ram_we), 32'd0);
      chk("mw_addr", 32'(bus.ram_addr), 32'd0);
      chk("mw_bus", 32'(ram_data), 32'(IDLE_BUS));
      @(negedge clk);
      chk_flags("mw_hold", 4'd0);

      // Reset while a read is in CAPTURE.
      do_push(16'h7777, 1'b1);
      bus.pop = 1'b1;
      @(negedge clk);
      bus.pop = 1'b0;
      @(negedge clk);
      chk("mc_re", 32'(bus.ram_re), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exp_wptr = 3'd0;
      exp_rptr = 3'd0;
      chk_flags("mc", 4'd0);
      chk("mc_valid", 32'(bus.dout_valid), 32'd0);
      chk("mc_re_after", 32'(bus.ram_re), 32'd0);
      chk("mc_bus", 32'(ram_data), 32'(IDLE_BUS));
      @(negedge clk);
      chk("mc_valid_next", 32'(bus.dout_valid), 32'd0);

      do_push(16'hC3A5, 1'b1);
      do_pop(1'b1);
      chk_flags("post_reset", 4'd0);
      @(negedge clk);
      chk("sb_left", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the 8x16 single-port RAM and uses it as FIFO storage. It turns a push/pop stream interface into RAM write and read cycles, serialising both onto the RAM's single address port and bidirectional data bus. It owns the write/read pointers, the occupancy count and the bus direction. It does not hold any data storage of its own beyond one write holding register and the output register.

## Interface
- WIDTH, 16, data word width
- DEPTH, 8, RAM words / FIFO capacity
- ADDR_BUS, 3, RAM address width (log2 DEPTH)

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge
- push  input  1  write request
- din  input  WIDTH  write data, captured when push accepted
- push_rdy  output  1  push accepted this cycle when push && push_rdy
- pop  input  1  read request
- pop_rdy  output  1  pop accepted this cycle when pop && pop_rdy
- dout  output  WIDTH  read data, valid while dout_valid
- dout_valid  output  1  one-cycle pulse, dout holds popped word
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  ADDR_BUS+1  occupancy, 0..8
- ram_we  output  1  RAM write enable
- ram_re  output  1  RAM read enable
- ram_addr  output  ADDR_BUS  RAM address
- ram_data  inout  WIDTH  RAM data bus; driven only when ram_we && !ram_re, else high-Z

## Operation
- FSM states: IDLE, WRITE, READ, CAPTURE.
- IDLE: pop_rdy = !empty. push_rdy = !full && !(pop && !empty). Pop has priority over a simultaneous push.
  - On pop accepted, go to READ. ram_addr <= rd_ptr.
  - Else on push accepted, go to WRITE. wdata <= din, ram_addr <= wr_ptr.
  - Else stay in IDLE.
- WRITE, one cycle: ram_we=1, ram_re=0, ram_data=wdata. On exit: wr_ptr++, count++, go to IDLE.
- READ, one cycle: ram_re=1, ram_we=0, ram_data high-Z, go to CAPTURE.
- CAPTURE, one cycle: ram_re and ram_addr held. dout <= ram_data, dout_valid <= 1, rd_ptr++, count--, go to IDLE.
  - Holding addr/re across two cycles makes this valid for both combinational-read and one-cycle-registered-read RAM.
- push_rdy = pop_rdy = 0 in every state other than IDLE.
- Pointers are ADDR_BUS bits and wrap naturally, 7 -> 0. Count is ADDR_BUS+1 bits and never exceeds DEPTH or drops below 0.
- Bus contention is never allowed: ram_we and ram_re are never both 1. ram_data is released (Z) in every cycle that ram_we is 0.
- The controller does not clear RAM contents. After reset, stale words are unreachable because count is 0.

## Timing
- Reset (rst=0 at a rising edge) gives:
  - state=IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0.
  - push_rdy=1, pop_rdy=0.
  - dout=0, dout_valid=0.
  - ram_we=0, ram_re=0, ram_addr=0, ram_data=Z.
- Reset dominates any state. A WRITE or READ in flight is abandoned at that edge, with no pointer or count update.
- Push latency: accepted in cycle N, RAM write in cycle N+1, count updated and visible in N+2, push_rdy high again in N+2.
- Pop latency: accepted in cycle N, READ in N+1, CAPTURE in N+2, dout_valid=1 in N+3 for exactly one cycle. dout holds its value until the next capture.
- Throughput: at most one push per 2 cycles, one pop per 3 cycles.
- ram_we, ram_re and ram_addr are registered outputs. empty, full, push_rdy and pop_rdy are combinational from registered state, count and the inputs.
- Push while full, or pop while empty: not accepted, no state change.

## Test plan
- Reset: hold rst=0 two cycles with push=pop=1 -> count=0, empty=1, full=0, ram_we=ram_re=0, ram_data=Z, dout_valid=0.
- Single word: push din=16'hA465 -> ram_we=1, ram_addr=0, ram_data=A465 one cycle later. Then pop -> dout_valid=1 with dout=A465 three cycles after acceptance; count returns to 0.
- Fill and overflow: push 16'h0001..16'h0008 -> full=1, count=8. A ninth push of 16'hFFFF is refused (push_rdy=0) and count stays 8.
- Drain with wrap: from full, pop 3 times (get 0001..0003), push 16'h0009..16'h000B (written to addr 0,1,2), then pop all -> output order 0004..000B, empty=1, underflow pop refused.
- Simultaneous push+pop in IDLE with count=2 -> pop taken first, push_rdy=0 that cycle. The push re-presented after pop completes is accepted, and count ends at 2.
- Reset mid-WRITE and mid-CAPTURE -> pointers and count return to 0, dout_valid stays 0, and no bus is driven in the following cycle.
